taxi_fare_core: RTL and testbench

TAXI_FARE_CORE -- requirements
Module: taxi_fare_core

---
 rtl/taxi_fare_core_if.sv | 42 ++++
 rtl/taxi_fare_core.sv | 173 +++++++++++++++++
 tb/tb_taxi_fare_core.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_fare_core_if.sv
// ============================================================================
// Module  : taxi_fare_core_if
// Brief   : Trip-control, tariff-config and fare-status bundle for the fare core.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface taxi_fare_core_if #(
   parameter int W     = 12,
   parameter int NPROF = 2
);
   localparam int PW = (NPROF <= 2) ? 1 : $clog2(NPROF);

   logic          cfg_we;
   logic [PW-1:0] cfg_prof;
   logic [1:0]    cfg_field;
   logic [W-1:0]  cfg_data;
   logic [PW-1:0] prof_sel;
   logic          start;
   logic          stop;
   logic          pause;
   logic          km_pulse;
   logic          wait_tick;
   logic [W-1:0]  len;
   logic [W-1:0]  cost;
   logic [1:0]    state;
   logic          sat;

   modport master (
      output cfg_we, cfg_prof, cfg_field, cfg_data, prof_sel,
      output start, stop, pause, km_pulse, wait_tick,
      input  len, cost, state, sat
   );

   modport slave (
      input  cfg_we, cfg_prof, cfg_field, cfg_data, prof_sel,
      input  start, stop, pause, km_pulse, wait_tick,
      output len, cost, state, sat
   );
endinterface

`default_nettype wire

// File: rtl/taxi_fare_core.sv
// ============================================================================
// Module  : taxi_fare_core
// Brief   : Taximeter fare engine with per-profile tariffs and saturating fare.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module taxi_fare_core #(
   parameter int W     = 12,
   parameter int NPROF = 2
) (
   input  wire logic          clk,
   input  wire logic          reset,
   taxi_fare_core_if.slave    bus
);
   localparam int PW = (NPROF <= 2) ? 1 : $clog2(NPROF);

   localparam logic [W-1:0] c_DEF_INIT  = W'(9);
   localparam logic [W-1:0] c_DEF_FREE  = W'(3);
   localparam logic [W-1:0] c_DEF_PPK   = W'(3);
   localparam logic [W-1:0] c_DEF_WAIT  = W'(3);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_len;
   logic [W-1:0]  r_cost;
   logic          r_sat;
   logic [W-1:0]  r_wcnt;
   logic [PW-1:0] r_prof;

   logic [W-1:0]  r_init_price   [NPROF];
   logic [W-1:0]  r_free_len     [NPROF];
   logic [W-1:0]  r_price_per_km [NPROF];
   logic [W-1:0]  r_wait_ticks   [NPROF];

   logic [W-1:0]  w_start_init;
   logic [W-1:0]  w_start_wait;
   logic [W-1:0]  w_free_len;
   logic [W-1:0]  w_ppk;
   logic [W-1:0]  w_wait_ticks;
   logic          w_cfg_wr;
   logic [W:0]    w_len_inc;
   logic [W:0]    w_cost_add;
   logic          w_km_charge;

   // Returns {overflow, clamped sum}.
   function automatic logic [W:0] add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[W]) begin
         s = {1'b1, {W{1'b1}}};
      end
      return s;
   endfunction

   // Start reads the requested profile; a running trip only sees the latched one.
   always_comb begin
      w_start_init = r_init_price[0];
      w_start_wait = r_wait_ticks[0];
      w_free_len   = r_free_len[0];
      w_ppk        = r_price_per_km[0];
      w_wait_ticks = r_wait_ticks[0];
      for (int p = 1; p < NPROF; p++) begin
         if (bus.prof_sel == PW'(p)) begin
            w_start_init = r_init_price[p];
            w_start_wait = r_wait_ticks[p];
         end
         if (r_prof == PW'(p)) begin
            w_free_len   = r_free_len[p];
            w_ppk        = r_price_per_km[p];
            w_wait_ticks = r_wait_ticks[p];
         end
      end
   end

   assign w_cfg_wr    = bus.cfg_we && (r_state == S_IDLE || r_state == S_DONE);
   assign w_len_inc   = add_sat(r_len, W'(1));
   assign w_cost_add  = add_sat(r_cost, w_ppk);
   assign w_km_charge = (w_len_inc[W-1:0] > w_free_len);

   // Out-of-range cfg_prof matches no profile and is therefore dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NPROF; p++) begin
            r_init_price[p]   <= c_DEF_INIT;
            r_free_len[p]     <= c_DEF_FREE;
            r_price_per_km[p] <= c_DEF_PPK;
            r_wait_ticks[p]   <= c_DEF_WAIT;
         end
      end else if (w_cfg_wr) begin
         for (int p = 0; p < NPROF; p++) begin
            if (bus.cfg_prof == PW'(p)) begin
               case (bus.cfg_field)
                  2'd0:    r_init_price[p]   <= bus.cfg_data;
                  2'd1:    r_free_len[p]     <= bus.cfg_data;
                  2'd2:    r_price_per_km[p] <= bus.cfg_data;
                  default: r_wait_ticks[p]   <= bus.cfg_data;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_len   <= '0;
         r_cost  <= c_DEF_INIT;
         r_sat   <= 1'b0;
         r_wcnt  <= '0;
         r_prof  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_state <= S_RUN;
                  r_prof  <= bus.prof_sel;
                  r_len   <= '0;
                  r_cost  <= w_start_init;
                  r_sat   <= 1'b0;
                  r_wcnt  <= w_start_wait;
               end
            end
            S_RUN: begin
               if (bus.stop) begin
                  r_state <= S_DONE;
               end else begin
                  if (bus.km_pulse) begin
                     r_len <= w_len_inc[W-1:0];
                     if (w_km_charge) begin
                        r_cost <= w_cost_add[W-1:0];
                     end
                     r_sat <= r_sat | w_len_inc[W] | (w_km_charge & w_cost_add[W]);
                  end
                  if (bus.pause) begin
                     r_state <= S_PAUSED;
                     r_wcnt  <= w_wait_ticks;
                  end
               end
            end
            default: begin
               if (bus.stop) begin
                  r_state <= S_DONE;
               end else if (!bus.pause) begin
                  r_state <= S_RUN;
               end else if (bus.wait_tick) begin
                  if (r_wcnt != '0) begin
                     r_wcnt <= r_wcnt - W'(1);
                  end else begin
                     r_cost <= w_cost_add[W-1:0];
                     r_sat  <= r_sat | w_cost_add[W];
                     r_wcnt <= w_wait_ticks;
                  end
               end
            end
         endcase
      end
   end

   assign bus.len   = r_len;
   assign bus.cost  = r_cost;
   assign bus.state = r_state;
   assign bus.sat   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_taxi_fare_core.sv
// ============================================================================
// Module  : tb_taxi_fare_core
// Brief   : Directed and randomized checking of taxi_fare_core against a fare model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_taxi_fare_core;
   localparam int W     = 12;
   localparam int NPROF = 2;
   localparam int PW    = (NPROF <= 2) ? 1 : $clog2(NPROF);
   localparam int MAXV  = (1 << W) - 1;
   localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_DONE = 3;

   logic clk;
   logic reset;
   bit   cmp_en;
   int   n_checks;
   int   n_pass;

   taxi_fare_core_if #(.W(W), .NPROF(NPROF)) bus ();

   taxi_fare_core #(.W(W), .NPROF(NPROF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Fare model: tariff tables and trip status as plain integers.
   int m_ip [NPROF];
   int m_fl [NPROF];
   int m_ppk[NPROF];
   int m_wt [NPROF];
   int m_state, m_len, m_cost, m_sat, m_wcnt, m_prof;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int sadd(input int a, input int b);
      if (a + b > MAXV) begin
         m_sat = 1;
         return MAXV;
      end
      return a + b;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NPROF; p++) begin
         m_ip[p] = 9; m_fl[p] = 3; m_ppk[p] = 3; m_wt[p] = 3;
      end
      m_state = ST_IDLE; m_len = 0; m_cost = 9; m_sat = 0; m_wcnt = 0; m_prof = 0;
   endtask

   task automatic model_step();
      bit cfg_ok;
      int pr, fld, dat;
      if (!reset) begin
         model_reset();
         return;
      end
      cfg_ok = bus.cfg_we && (m_state == ST_IDLE || m_state == ST_DONE) && int'(bus.cfg_prof) < NPROF;
      pr = int'(bus.cfg_prof); fld = int'(bus.cfg_field); dat = int'(bus.cfg_data);
      if (m_state == ST_IDLE || m_state == ST_DONE) begin
         if (bus.start) begin
            m_prof = int'(bus.prof_sel);
            m_len = 0; m_cost = m_ip[m_prof]; m_sat = 0; m_wcnt = m_wt[m_prof];
            m_state = ST_RUN;
         end
      end else if (bus.stop) begin
         m_state = ST_DONE;
      end else if (m_state == ST_RUN) begin
         if (bus.km_pulse) begin
            m_len = sadd(m_len, 1);
            if (m_len > m_fl[m_prof]) m_cost = sadd(m_cost, m_ppk[m_prof]);
         end
         if (bus.pause) begin
            m_state = ST_PAUSED;
            m_wcnt = m_wt[m_prof];
         end
      end else begin
         if (!bus.pause) m_state = ST_RUN;
         else if (bus.wait_tick) begin
            if (m_wcnt > 0) m_wcnt--;
            else begin
               m_cost = sadd(m_cost, m_ppk[m_prof]);
               m_wcnt = m_wt[m_prof];
            end
         end
      end
      if (cfg_ok) begin
         case (fld)
            0: m_ip[pr] = dat;
            1: m_fl[pr] = dat;
            2: m_ppk[pr] = dat;
            default: m_wt[pr] = dat;
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("len", bus.len, m_len);
         check("cost", bus.cost, m_cost);
         check("state", bus.state, m_state);
         check("sat", bus.sat, m_sat);
      end
   end

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      bus.start = 0; bus.stop = 0; bus.km_pulse = 0; bus.wait_tick = 0; bus.cfg_we = 0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic cfg(input int prof, input int field, input int data);
      bus.cfg_we = 1; bus.cfg_prof = PW'(prof); bus.cfg_field = 2'(field); bus.cfg_data = W'(data);
      step();
   endtask

   task automatic start_trip(input int prof);
      bus.prof_sel = PW'(prof); bus.start = 1;
      step();
   endtask

   task automatic stop_trip();
      bus.stop = 1;
      step();
   endtask

   task automatic km(input int n);
      for (int i = 0; i < n; i++) begin
         bus.km_pulse = 1;
         step();
      end
   endtask

   task automatic pulse_reset();
      reset = 0;
      model_reset();
      #1;
      check("rst_state", bus.state, ST_IDLE);
      check("rst_len", bus.len, 0);
      check("rst_cost", bus.cost, 9);
      steps(2);
      reset = 1;
   endtask

   initial begin
      clk = 0; reset = 0; cmp_en = 0; n_checks = 0; n_pass = 0;
      bus.cfg_we = 0; bus.cfg_prof = '0; bus.cfg_field = '0; bus.cfg_data = '0;
      bus.prof_sel = '0; bus.start = 0; bus.stop = 0; bus.pause = 0;
      bus.km_pulse = 0; bus.wait_tick = 0;
      model_reset();
      #1;
      cmp_en = 1;
      steps(2);
      reset = 1;
      step();

      // Default tariff: free distance of 3, then 3 per unit.
      start_trip(0);
      km(5);
      check("d034_len", bus.len, 5);
      check("d034_cost", bus.cost, 15);
      check("d034_state", bus.state, ST_RUN);
      check("d034_model", m_cost, 15);
      stop_trip();
      check("d034_done", bus.state, ST_DONE);

      cfg(1, 0, 12); cfg(1, 2, 5); cfg(1, 1, 0);
      start_trip(1);
      bus.prof_sel = '0;
      km(2);
      check("d035_cost", bus.cost, 22);
      check("d035_model", m_cost, 22);
      stop_trip();

      start_trip(0);
      bus.pause = 1;
      step();
      check("d036_paused", bus.state, ST_PAUSED);
      for (int i = 0; i < 8; i++) begin
         bus.wait_tick = 1; bus.km_pulse = 1;
         step();
      end
      check("d036_cost", bus.cost, 15);
      check("d036_len", bus.len, 0);
      check("d036_model", m_cost, 15);
      bus.pause = 0;
      step();
      check("d036_resume", bus.state, ST_RUN);
      km(1);
      cfg(0, 0, 100);
      bus.km_pulse = 1;
      stop_trip();
      check("d038_state", bus.state, ST_DONE);
      check("d038_len", bus.len, 1);
      start_trip(0);
      check("d038_cfg_run_ignored", bus.cost, 9);
      stop_trip();
      cfg(0, 0, 100);
      bus.stop = 1;
      start_trip(0);
      check("d038_cfg_done_taken", bus.cost, 100);
      check("d027_start_wins", bus.state, ST_RUN);
      stop_trip();

      cfg(0, 0, 4094); cfg(0, 1, 0);
      start_trip(0);
      km(1);
      check("d037_cost", bus.cost, 4095);
      check("d037_sat", bus.sat, 1);
      km(1);
      check("d037_hold", bus.cost, 4095);
      stop_trip();
      start_trip(0);
      check("d037_sat_clr", bus.sat, 0);
      check("d037_restart", bus.cost, 4094);
      km(2);
      pulse_reset();
      start_trip(1);
      check("d039_prof_default", bus.cost, 9);
      stop_trip();

      for (int i = 0; i < 4000; i++) begin
         bus.start     = ($urandom_range(0, 15) == 0);
         bus.stop      = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
         bus.km_pulse  = ($urandom_range(0, 2) == 0);
         bus.wait_tick = ($urandom_range(0, 1) == 0);
         bus.prof_sel  = PW'($urandom_range(0, NPROF - 1));
         bus.cfg_we    = ($urandom_range(0, 3) == 0);
         bus.cfg_prof  = PW'($urandom_range(0, NPROF - 1));
         bus.cfg_field = 2'($urandom_range(0, 3));
         bus.cfg_data  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(MAXV - 15, MAXV))
                                                     : W'($urandom_range(0, 6));
         if (i % 1000 == 777) pulse_reset();
         else step();
      end

      cmp_en = 0;
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
